mem_port_arbiter: RTL and testbench

Shares the single SRAM-like memory port between the instruction-fetch requester and the data-access requester of the pipeline. Grants one request per cycle with data priority and locks a presented but unaccepted request until the slave takes it. Records the source of every accepted request in an in-order route FIFO, so each `data_ok` response is steered back to the requester that issued it. Sits between the IF and EX/MEM stages and the memory bridge.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_port_arbiter_route_fifo.sv | 63 ++++++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the IF/MEM memory-port arbiter:
// source IDs, grant states and access-size encodings.
package mem_arb_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } grant_state_e;

  function automatic grant_state_e lock_state(input logic src);
    return (src == SRC_DATA) ? LOCK_DATA : LOCK_INST;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_route_fifo.sv
// In-order FIFO of 1-bit source IDs, one entry per accepted memory request.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module route_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          push_src,
  input  logic          pop,
  output logic          head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_r    <= {DEPTH{SRC_INST}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_src;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the instruction and data requesters onto one SRAM-like port,
// holding a presented request until accepted and routing responses in order.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int CW = $clog2(DEPTH + 1);

  grant_state_e  state_r;
  logic          err_r;
  logic          grant_valid_s;
  logic          grant_src_s;
  logic          src_req_s;
  logic          can_issue_s;
  logic          accept_s;
  logic          resp_s;
  logic          head_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;

  // Grant selection: a locked source keeps the port, otherwise data wins
  always_comb begin
    grant_valid_s = 1'b0;
    grant_src_s   = SRC_INST;
    case (state_r)
      IDLE: begin
        if (data_req) begin
          grant_valid_s = 1'b1;
          grant_src_s   = SRC_DATA;
        end else if (inst_req) begin
          grant_valid_s = 1'b1;
          grant_src_s   = SRC_INST;
        end else begin
          grant_valid_s = 1'b0;
          grant_src_s   = SRC_INST;
        end
      end
      LOCK_INST: begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_INST;
      end
      LOCK_DATA: begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_DATA;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_src_s   = SRC_INST;
      end
    endcase
  end

  // Responses free a slot in the same cycle, so data_ok may admit a request at full
  assign src_req_s   = (grant_src_s == SRC_DATA) ? data_req : inst_req;
  assign can_issue_s = (count_s < CW'(DEPTH)) | mem_data_ok;
  assign mem_req     = ~reset & grant_valid_s & src_req_s & can_issue_s;
  assign accept_s    = mem_req & mem_addr_ok;

  // Request-field mux from the granted source, zero when nothing is granted
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (~reset & grant_valid_s) begin
      if (grant_src_s == SRC_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end else begin
      mem_wr    = 1'b0;
      mem_size  = 2'd0;
      mem_wstrb = 4'd0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  assign inst_addr_ok = accept_s & (grant_src_s == SRC_INST);
  assign data_addr_ok = accept_s & (grant_src_s == SRC_DATA);
  assign resp_s       = ~reset & mem_data_ok & ~empty_s;
  assign inst_data_ok = resp_s & (head_s == SRC_INST);
  assign data_data_ok = resp_s & (head_s == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err          = err_r;

  route_fifo #(.DEPTH(DEPTH), .CW(CW)) u_route_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept_s),
    .push_src (grant_src_s),
    .pop      (resp_s),
    .head     (head_s),
    .count    (count_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // Lock state machine and sticky stray-response error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      err_r   <= 1'b0;
    end else begin
      if (mem_data_ok & empty_s) begin
        err_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (mem_req & ~mem_addr_ok) begin
            state_r <= lock_state(grant_src_s);
          end
        end
        LOCK_INST, LOCK_DATA: begin
          if (accept_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  logic unused_s;
  assign unused_s = full_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue-based
// model of the arbiter (priority, hold-until-accepted, in-order routing).
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        r_req [2];
  logic        r_wr  [2];
  logic [1:0]  r_size[2];
  logic [3:0]  r_strb[2];
  logic [31:0] r_addr[2];
  logic [31:0] r_wdat[2];
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err;
  logic [5:0]  ctrl;
  logic [70:0] flds;
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  assign ctrl = {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err};
  assign flds = {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata};

  mem_port_arbiter #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(r_req[0]), .inst_wr(r_wr[0]), .inst_size(r_size[0]), .inst_wstrb(r_strb[0]),
    .inst_addr(r_addr[0]), .inst_wdata(r_wdat[0]),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(r_req[1]), .data_wr(r_wr[1]), .data_size(r_size[1]), .data_wstrb(r_strb[1]),
    .data_addr(r_addr[1]), .data_wdata(r_wdat[1]),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int s, input logic wr, input logic [1:0] size,
                         input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wd);
    r_req[s] = 1'b1; r_wr[s] = wr; r_size[s] = size;
    r_strb[s] = strb; r_addr[s] = addr; r_wdat[s] = wd;
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 2; s++) begin
      r_req[s] = 1'b0; r_wr[s] = 1'b0; r_size[s] = 2'd0;
      r_strb[s] = 4'd0; r_addr[s] = 32'd0; r_wdat[s] = 32'd0;
    end
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    set_req(0, 1'b1, 2'd2, 4'hF, 32'h1000, 32'h1111);
    set_req(1, 1'b1, 2'd2, 4'hF, 32'h2000, 32'h2222);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #1;
    chk_cnt++; if (ctrl !== 6'b0) $display("FAIL reset_ctrl: got %b want %b", ctrl, 6'b0); else pass_cnt++;
    chk_cnt++; if (flds !== 71'd0) $display("FAIL reset_fields: got %h want 0", flds); else pass_cnt++;
    step();
    clear_inputs();
    reset = 1'b0;
    #1;
    chk_cnt++; if (ctrl !== 6'b0) $display("FAIL post_reset_ctrl: got %b want %b", ctrl, 6'b0); else pass_cnt++;
  endtask

  task automatic test_priority();
    do_reset();
    set_req(0, 1'b0, 2'd2, 4'hF, 32'h1000, 32'h0);
    set_req(1, 1'b0, 2'd2, 4'hF, 32'h2000, 32'h0);
    mem_addr_ok = 1'b1;
    #1;
    chk_cnt++; if ({ctrl, mem_addr} !== {6'b101000, 32'h2000}) $display("FAIL prio_data_first: got %b/%h want 101000/2000", ctrl, mem_addr); else pass_cnt++;
    step();
    r_req[1] = 1'b0;
    #1;
    chk_cnt++; if ({ctrl, mem_addr} !== {6'b110000, 32'h1000}) $display("FAIL prio_inst_next: got %b/%h want 110000/1000", ctrl, mem_addr); else pass_cnt++;
    step();
    r_req[0] = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hAAAA;
    #1;
    chk_cnt++; if ({ctrl, data_rdata} !== {6'b000010, 32'hAAAA}) $display("FAIL prio_resp_data: got %b/%h want 000010/aaaa", ctrl, data_rdata); else pass_cnt++;
    step();
    mem_rdata = 32'hBBBB;
    #1;
    chk_cnt++; if ({ctrl, inst_rdata} !== {6'b000100, 32'hBBBB}) $display("FAIL prio_resp_inst: got %b/%h want 000100/bbbb", ctrl, inst_rdata); else pass_cnt++;
    step();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_lock();
    do_reset();
    set_req(0, 1'b0, 2'd2, 4'hF, 32'h1000, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) set_req(1, 1'b0, 2'd2, 4'hF, 32'h2000, 32'h0);
      #1;
      chk_cnt++; if ({ctrl, mem_addr} !== {6'b100000, 32'h1000}) $display("FAIL lock_hold_c%0d: got %b/%h want 100000/1000", c, ctrl, mem_addr); else pass_cnt++;
      step();
    end
    mem_addr_ok = 1'b1;
    #1;
    chk_cnt++; if ({ctrl, mem_addr} !== {6'b110000, 32'h1000}) $display("FAIL lock_accept: got %b/%h want 110000/1000", ctrl, mem_addr); else pass_cnt++;
    step();
    r_req[0] = 1'b0;
    #1;
    chk_cnt++; if ({ctrl, mem_addr} !== {6'b101000, 32'h2000}) $display("FAIL lock_then_data: got %b/%h want 101000/2000", ctrl, mem_addr); else pass_cnt++;
    step();
    r_req[1] = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk_cnt++; if (ctrl !== 6'b000100) $display("FAIL lock_resp1: got %b want 000100", ctrl); else pass_cnt++;
    step();
    chk_cnt++; if (ctrl !== 6'b000010) $display("FAIL lock_resp2: got %b want 000010", ctrl); else pass_cnt++;
    step();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    mem_addr_ok = 1'b1;
    set_req(0, 1'b0, 2'd2, 4'hF, 32'h10, 32'h0);
    #1;
    chk_cnt++; if (ctrl !== 6'b110000) $display("FAIL full_acc1: got %b want 110000", ctrl); else pass_cnt++;
    step();
    set_req(0, 1'b0, 2'd2, 4'hF, 32'h14, 32'h0);
    #1;
    chk_cnt++; if (ctrl !== 6'b110000) $display("FAIL full_acc2: got %b want 110000", ctrl); else pass_cnt++;
    step();
    r_req[0] = 1'b0;
    set_req(1, 1'b0, 2'd2, 4'hF, 32'h20, 32'h0);
    #1;
    chk_cnt++; if ({ctrl, mem_addr} !== {6'b000000, 32'h20}) $display("FAIL full_blocks: got %b/%h want 000000/20", ctrl, mem_addr); else pass_cnt++;
    step();
    mem_data_ok = 1'b1;
    #1;
    chk_cnt++; if (ctrl !== 6'b101100) $display("FAIL full_same_cycle: got %b want 101100", ctrl); else pass_cnt++;
    step();
    mem_data_ok = 1'b0; r_req[1] = 1'b0;
    set_req(0, 1'b0, 2'd2, 4'hF, 32'h18, 32'h0);
    #1;
    chk_cnt++; if (ctrl !== 6'b000000) $display("FAIL full_count_stays: got %b want 000000", ctrl); else pass_cnt++;
    step();
    r_req[0] = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk_cnt++; if (ctrl !== 6'b000100) $display("FAIL full_drain1: got %b want 000100", ctrl); else pass_cnt++;
    step();
    chk_cnt++; if (ctrl !== 6'b000010) $display("FAIL full_drain2: got %b want 000010", ctrl); else pass_cnt++;
    step();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_write();
    do_reset();
    set_req(1, 1'b1, 2'd1, 4'b0011, 32'h3002, 32'hDEADBEEF);
    mem_addr_ok = 1'b1;
    #1;
    chk_cnt++; if (flds !== {1'b1, 2'd1, 4'b0011, 32'h3002, 32'hDEADBEEF}) $display("FAIL write_fields: got %h want %h", flds, {1'b1, 2'd1, 4'b0011, 32'h3002, 32'hDEADBEEF}); else pass_cnt++;
    chk_cnt++; if (ctrl !== 6'b101000) $display("FAIL write_accept: got %b want 101000", ctrl); else pass_cnt++;
    step();
    r_req[1] = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk_cnt++; if (ctrl !== 6'b000010) $display("FAIL write_resp: got %b want 000010", ctrl); else pass_cnt++;
    step();
    mem_data_ok = 1'b0;
  endtask

  task automatic test_stray();
    do_reset();
    mem_data_ok = 1'b1;
    #1;
    chk_cnt++; if (ctrl !== 6'b000000) $display("FAIL stray_no_route: got %b want 000000", ctrl); else pass_cnt++;
    step();
    mem_data_ok = 1'b0;
    #1;
    chk_cnt++; if (err !== 1'b1) $display("FAIL stray_err_set: got %b want 1", err); else pass_cnt++;
    step();
    step();
    chk_cnt++; if (err !== 1'b1) $display("FAIL stray_err_sticky: got %b want 1", err); else pass_cnt++;
    reset = 1'b1;
    #1;
    chk_cnt++; if (err !== 1'b0) $display("FAIL stray_err_reset: got %b want 0", err); else pass_cnt++;
    step();
    reset = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_addr_ok = 1'b1;
    set_req(0, 1'b0, 2'd2, 4'hF, 32'h40, 32'h0);
    step();
    r_req[0] = 1'b0;
    set_req(1, 1'b0, 2'd2, 4'hF, 32'h44, 32'h0);
    step();
    r_req[1] = 1'b0;
    set_req(0, 1'b0, 2'd2, 4'hF, 32'h48, 32'h0);
    mem_data_ok = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk_cnt++; if ({ctrl, flds} !== {6'b0, 71'd0}) $display("FAIL areset_outputs: got %b/%h want 0/0", ctrl, flds); else pass_cnt++;
    step();
    clear_inputs();
    reset = 1'b0;
    mem_data_ok = 1'b1;
    #1;
    chk_cnt++; if (ctrl !== 6'b000000) $display("FAIL areset_routes_gone: got %b want 000000", ctrl); else pass_cnt++;
    step();
    mem_data_ok = 1'b0;
    #1;
    chk_cnt++; if (err !== 1'b1) $display("FAIL areset_stray_err: got %b want 1", err); else pass_cnt++;
  endtask

  task automatic test_random();
    int          q[$];
    int          lk;
    int          ch;
    int          acc;
    logic        can, exp_req, aok, dok;
    logic [31:0] rd;
    logic [5:0]  exp_ctrl;
    logic [70:0] exp_flds;
    do_reset();
    lk = -1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int s = 0; s < 2; s++) begin
        if (!r_req[s] && ($urandom % 3 == 0))
          set_req(s, 1'($urandom), 2'($urandom_range(0, 2)), 4'($urandom), $urandom, $urandom);
      end
      aok = 1'($urandom);
      dok = (q.size() > 0) && ($urandom % 3 == 0);
      rd  = $urandom;
      mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = rd;
      ch = lk;
      if (ch < 0) ch = r_req[1] ? 1 : (r_req[0] ? 0 : -1);
      can = (q.size() < 2) || dok;
      exp_req = (ch >= 0) && can;
      exp_flds = (ch >= 0) ? {r_wr[ch], r_size[ch], r_strb[ch], r_addr[ch], r_wdat[ch]} : 71'd0;
      exp_ctrl = {exp_req, exp_req && aok && ch == 0, exp_req && aok && ch == 1,
                  dok && q.size() > 0 && q[0] == 0, dok && q.size() > 0 && q[0] == 1, 1'b0};
      #1;
      chk_cnt++; if (ctrl !== exp_ctrl) $display("FAIL rand_ctrl cyc%0d: got %b want %b", cyc, ctrl, exp_ctrl); else pass_cnt++;
      chk_cnt++; if (flds !== exp_flds) $display("FAIL rand_fields cyc%0d: got %h want %h", cyc, flds, exp_flds); else pass_cnt++;
      chk_cnt++; if ({inst_rdata, data_rdata} !== {rd, rd}) $display("FAIL rand_rdata cyc%0d: got %h/%h want %h", cyc, inst_rdata, data_rdata, rd); else pass_cnt++;
      acc = -1;
      if (dok && q.size() > 0) void'(q.pop_front());
      if (exp_req) begin
        if (aok) begin
          q.push_back(ch);
          lk  = -1;
          acc = ch;
        end else begin
          lk = ch;
        end
      end
      step();
      if (acc >= 0) r_req[acc] = 1'b0;
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_priority();
    test_lock();
    test_full();
    test_write();
    test_stray();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
